// File: rtl/paddle_ctrl_n.sv
// N-player paddle controller: PS/2 set-2 make/break decode into key state, ramped paddle motion with playfield clamp.
// Latency: key_state one cycle after the scan byte, paddle_y one cycle after move_tick/center; all outputs registered.
// Backpressure: none; every scan_ready byte and every move_tick is consumed in the cycle it is presented.
module paddle_ctrl_n #(
    parameter int          NUM_PADDLES = 2,
    parameter int          Y_W         = 10,
    parameter int          SCREEN_H    = 480,
    parameter int          PADDLE_H    = 60,
    parameter int          SPEED_MIN   = 2,
    parameter int          SPEED_MAX   = 8,
    parameter int          ACCEL_TICKS = 8,
    parameter logic [71:0] KEYMAP      = {9'h072, 9'h075, 9'h172, 9'h175,
                                          9'h042, 9'h043, 9'h01B, 9'h01D}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         move_tick,
    input  logic [7:0]                   scan_code,
    input  logic                         scan_ready,
    input  logic                         center,
    input  logic                         enable,
    output logic [NUM_PADDLES*Y_W-1:0]   paddle_y,
    output logic [2*NUM_PADDLES-1:0]     key_state
);

    localparam int YMAX  = SCREEN_H - PADDLE_H;
    localparam int YW1   = Y_W + 1;
    localparam int SPD_W = $clog2(SPEED_MAX + 1);
    localparam int HC_W  = $clog2(ACCEL_TICKS);

    localparam logic [Y_W-1:0]   Y_CENTER = Y_W'(YMAX / 2);
    localparam logic [Y_W:0]     YMAX_X   = YW1'(YMAX);
    localparam logic [SPD_W-1:0] SPD_MIN  = SPD_W'(SPEED_MIN);
    localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(SPEED_MAX);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(ACCEL_TICKS - 1);

    typedef enum logic [1:0] {DEC_IDLE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_e;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_e;

    dec_state_e                         dec_q;
    logic [2*NUM_PADDLES-1:0]           key_q;
    logic                               is_e0;
    logic                               is_f0;

    logic [NUM_PADDLES-1:0][Y_W-1:0]    y_q, y_d;
    dir_e                               dir_q   [NUM_PADDLES];
    dir_e                               dir_d   [NUM_PADDLES];
    dir_e                               dir_req [NUM_PADDLES];
    logic [SPD_W-1:0]                   spd_q   [NUM_PADDLES];
    logic [SPD_W-1:0]                   spd_d   [NUM_PADDLES];
    logic [HC_W-1:0]                    hc_q    [NUM_PADDLES];
    logic [HC_W-1:0]                    hc_d    [NUM_PADDLES];
    logic [Y_W:0]                       step_x  [NUM_PADDLES];
    logic [Y_W:0]                       nxt_x   [NUM_PADDLES];

    assign is_e0     = (scan_code == 8'hE0);
    assign is_f0     = (scan_code == 8'hF0);
    assign key_state = key_q;
    assign paddle_y  = y_q;

    // Set (make) or clear (break) every key bit whose map entry matches the code.
    function automatic logic [2*NUM_PADDLES-1:0] apply_key(
        input logic [2*NUM_PADDLES-1:0] cur,
        input logic [8:0]               code,
        input logic                     make
    );
        logic [2*NUM_PADDLES-1:0] nxt;
        nxt = cur;
        for (int i = 0; i < 2*NUM_PADDLES; i++) begin
            if (KEYMAP[9*i +: 9] == code) nxt[i] = make;
        end
        return nxt;
    endfunction

    // Scan-code decoder: prefix tracking and key state, advanced only on received bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= DEC_IDLE;
            key_q <= '0;
        end else if (scan_ready) begin
            unique case (dec_q)
                DEC_IDLE: begin
                    if (is_e0)      dec_q <= DEC_EXT;
                    else if (is_f0) dec_q <= DEC_BRK;
                    else            key_q <= apply_key(key_q, {1'b0, scan_code}, 1'b1);
                end
                DEC_EXT: begin
                    if (is_f0) begin
                        dec_q <= DEC_EXT_BRK;
                    end else if (!is_e0) begin
                        key_q <= apply_key(key_q, {1'b1, scan_code}, 1'b1);
                        dec_q <= DEC_IDLE;
                    end
                end
                DEC_BRK: begin
                    if (is_e0) begin
                        dec_q <= DEC_EXT_BRK;
                    end else if (!is_f0) begin
                        key_q <= apply_key(key_q, {1'b0, scan_code}, 1'b0);
                        dec_q <= DEC_IDLE;
                    end
                end
                DEC_EXT_BRK: begin
                    if (!is_e0 && !is_f0) begin
                        key_q <= apply_key(key_q, {1'b1, scan_code}, 1'b0);
                        dec_q <= DEC_IDLE;
                    end
                end
                default: dec_q <= DEC_IDLE;
            endcase
        end
    end

    // Per-paddle next position and speed ramp; recenter beats disable beats tick.
    always_comb begin
        for (int p = 0; p < NUM_PADDLES; p++) begin
            y_d[p]     = y_q[p];
            dir_d[p]   = dir_q[p];
            spd_d[p]   = spd_q[p];
            hc_d[p]    = hc_q[p];
            step_x[p]  = '0;
            nxt_x[p]   = '0;
            if (key_q[2*p] && !key_q[2*p+1])      dir_req[p] = DIR_UP;
            else if (key_q[2*p+1] && !key_q[2*p]) dir_req[p] = DIR_DOWN;
            else                                  dir_req[p] = DIR_NONE;

            if (center || !enable || (move_tick && dir_req[p] == DIR_NONE)) begin
                dir_d[p] = DIR_NONE;
                spd_d[p] = SPD_MIN;
                hc_d[p]  = '0;
                if (center) y_d[p] = Y_CENTER;
            end else if (move_tick) begin
                if (dir_req[p] != dir_q[p]) begin
                    step_x[p] = YW1'(SPD_MIN);
                    spd_d[p]  = SPD_MIN;
                    hc_d[p]   = HC_W'(1);
                    dir_d[p]  = dir_req[p];
                end else begin
                    step_x[p] = YW1'(spd_q[p]);
                    if (hc_q[p] == HC_LAST) begin
                        hc_d[p]  = '0;
                        spd_d[p] = (spd_q[p] >= SPD_MAX) ? SPD_MAX : spd_q[p] + 1'b1;
                    end else begin
                        hc_d[p]  = hc_q[p] + 1'b1;
                    end
                end
                // Extra top bit keeps the subtract/add from wrapping before the clamp.
                if (dir_req[p] == DIR_UP) begin
                    nxt_x[p] = ({1'b0, y_q[p]} >= step_x[p]) ? {1'b0, y_q[p]} - step_x[p] : '0;
                end else begin
                    nxt_x[p] = {1'b0, y_q[p]} + step_x[p];
                    if (nxt_x[p] > YMAX_X) nxt_x[p] = YMAX_X;
                end
                y_d[p] = nxt_x[p][Y_W-1:0];
            end
        end
    end

    // Paddle position and ramp registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PADDLES; p++) begin
                y_q[p]   <= Y_CENTER;
                dir_q[p] <= DIR_NONE;
                spd_q[p] <= SPD_MIN;
                hc_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PADDLES; p++) begin
                y_q[p]   <= y_d[p];
                dir_q[p] <= dir_d[p];
                spd_q[p] <= spd_d[p];
                hc_q[p]  <= hc_d[p];
            end
        end
    end

endmodule

// File: tb/tb_paddle_ctrl_n.sv
// Directed bench for paddle_ctrl_n with four paddles and default geometry.
// Expected values come from a spec-level paddle model plus hand-derived constants, queued then drained.
// Outputs are sampled on the falling edge after each stimulus step.
module tb_paddle_ctrl_n;

    localparam int NP   = 4;
    localparam int YW   = 10;
    localparam int YMAX = 420;
    localparam int YC   = 210;
    localparam int SMIN = 2;
    localparam int SMAX = 8;
    localparam int ACC  = 8;

    logic               clk;
    logic               rst_n;
    logic               move_tick;
    logic [7:0]         scan_code;
    logic               scan_ready;
    logic               center;
    logic               enable;
    logic [NP*YW-1:0]   paddle_y;
    logic [2*NP-1:0]    key_state;

    paddle_ctrl_n #(.NUM_PADDLES(NP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .move_tick  (move_tick),
        .scan_code  (scan_code),
        .scan_ready (scan_ready),
        .center     (center),
        .enable     (enable),
        .paddle_y   (paddle_y),
        .key_state  (key_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard entry: kind 0 = whole paddle_y, 1 = key_state, 2 = one paddle's Y.
    typedef struct {
        string       tag;
        int          kind;
        int          pad;
        logic [39:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state.
    int         my  [NP];
    int         spd [NP];
    int         hc  [NP];
    int         ld  [NP];   // 0 none, 1 up, 2 down
    logic [7:0] mk;
    logic [8:0] km [8] = '{9'h01D, 9'h01B, 9'h043, 9'h042, 9'h175, 9'h172, 9'h075, 9'h072};

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            my[p] = YC; spd[p] = SMIN; hc[p] = 0; ld[p] = 0;
        end
        mk = '0;
    endtask

    task automatic model_move(input bit ctr, input bit en);
        for (int p = 0; p < NP; p++) begin
            int d;
            int step;
            d = (mk[2*p] && !mk[2*p+1]) ? 1 : ((mk[2*p+1] && !mk[2*p]) ? 2 : 0);
            if (ctr || !en || d == 0) begin
                ld[p] = 0; spd[p] = SMIN; hc[p] = 0;
                if (ctr) my[p] = YC;
            end else begin
                if (d != ld[p]) begin
                    step = SMIN; spd[p] = SMIN; hc[p] = 1; ld[p] = d;
                end else begin
                    step = spd[p];
                    if (hc[p] == ACC - 1) begin
                        hc[p] = 0;
                        if (spd[p] < SMAX) spd[p] = spd[p] + 1;
                    end else begin
                        hc[p] = hc[p] + 1;
                    end
                end
                if (d == 1) my[p] = (my[p] >= step) ? my[p] - step : 0;
                else        my[p] = (my[p] + step <= YMAX) ? my[p] + step : YMAX;
            end
        end
    endtask

    task automatic model_key(input logic [8:0] code, input bit v);
        for (int i = 0; i < 8; i++) if (km[i] == code) mk[i] = v;
    endtask

    task automatic push(input string tag, input int kind, input int pad, input logic [39:0] val);
        exp_t e;
        e.tag = tag; e.kind = kind; e.pad = pad; e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_y(input string tag);
        logic [39:0] v;
        for (int p = 0; p < NP; p++) v[YW*p +: YW] = YW'(my[p]);
        push(tag, 0, 0, v);
    endtask

    task automatic push_k(input string tag);
        push(tag, 1, 0, {32'd0, mk});
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [39:0] obs;
            e = sb.pop_front();
            case (e.kind)
                0:       obs = paddle_y;
                1:       obs = {32'd0, key_state};
                default: obs = {30'd0, paddle_y[YW*e.pad +: YW]};
            endcase
            n_chk++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_ready = 1'b1;
        @(negedge clk);
        scan_ready = 1'b0;
    endtask

    task automatic make_key(input logic [8:0] code);
        if (code[8]) send(8'hE0);
        send(code[7:0]);
        model_key(code, 1'b1);
    endtask

    task automatic break_key(input logic [8:0] code);
        if (code[8]) send(8'hE0);
        send(8'hF0);
        send(code[7:0]);
        model_key(code, 1'b0);
    endtask

    task automatic tick(input string tag, input bit ctr);
        @(negedge clk);
        move_tick = 1'b1;
        center    = ctr;
        @(negedge clk);
        move_tick = 1'b0;
        center    = 1'b0;
        model_move(ctr, enable);
        push_y(tag);
        drain();
    endtask

    int y_hold;

    initial begin
        rst_n = 1'b0; move_tick = 1'b0; scan_code = 8'h00; scan_ready = 1'b0;
        center = 1'b0; enable = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        push_y("reset_y");
        push_k("reset_keys");
        push("reset_p0_const", 2, 0, 40'd210);
        drain();

        // W held: eight ticks at step 2, ninth at step 3.
        make_key(9'h01D);
        push_k("w_make"); drain();
        for (int i = 0; i < 8; i++) tick("w_ramp", 1'b0);
        push("w_after8", 2, 0, 40'd194); drain();
        tick("w_tick9", 1'b0);
        push("w_after9", 2, 0, 40'd191); drain();
        break_key(9'h01D);
        push_k("w_break"); drain();
        tick("w_released", 1'b0);
        push("w_released_const", 2, 0, 40'd191); drain();
        make_key(9'h01D);
        tick("w_repress", 1'b0);
        push("w_repress_const", 2, 0, 40'd189); drain();
        break_key(9'h01D);

        // Extended vs plain codes sharing the byte 75.
        make_key(9'h175);
        push("ext75_make", 1, 0, 40'h10); drain();
        make_key(9'h075);
        push("kp8_make", 1, 0, 40'h50); drain();
        break_key(9'h175);
        push("ext75_break", 1, 0, 40'h40); drain();
        break_key(9'h075);
        push_k("kp8_break"); drain();

        // P1 down to the bottom bound, then up to the top bound.
        make_key(9'h042);
        for (int i = 0; i < 60; i++) tick("p1_down", 1'b0);
        push("p1_bottom", 2, 1, 40'd420); drain();
        break_key(9'h042);
        make_key(9'h043);
        for (int i = 0; i < 90; i++) tick("p1_up", 1'b0);
        push("p1_top", 2, 1, 40'd0); drain();
        break_key(9'h043);

        // Both W and S held: no movement; releasing S moves up by SPEED_MIN.
        y_hold = my[0];
        make_key(9'h01D);
        make_key(9'h01B);
        for (int i = 0; i < 5; i++) tick("both_held", 1'b0);
        push("both_const", 2, 0, 40'(y_hold)); drain();
        break_key(9'h01B);
        tick("s_released", 1'b0);
        push("s_released_const", 2, 0, 40'(y_hold - 2)); drain();

        // Hold W, then center coincident with tick, then fresh ramp.
        for (int i = 0; i < 20; i++) tick("w_hold20", 1'b0);
        tick("center", 1'b1);
        push("center_all", 0, 0, {4{10'd210}}); drain();
        tick("after_center", 1'b0);
        push("after_center_const", 2, 0, 40'd208); drain();

        // Disabled: no motion, keys still tracked, ramp restarts on re-enable.
        y_hold = my[0];
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) tick("disabled", 1'b0);
        push("disabled_const", 2, 0, 40'(y_hold)); drain();
        make_key(9'h01B);
        push("disabled_keys", 1, 0, 40'h03); drain();
        break_key(9'h01B);
        enable = 1'b1;
        tick("reenabled", 1'b0);
        push("reenabled_const", 2, 0, 40'(y_hold - 2)); drain();
        break_key(9'h01D);

        // Async reset between E0 and F0 discards the prefix.
        send(8'hE0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        push_y("midreset_y");
        push_k("midreset_keys");
        drain();
        make_key(9'h01D);
        push("after_reset_w", 1, 0, 40'h01); drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl_n.md
# paddle_ctrl_n

Parametrised N-player paddle controller for the Pong datapath. It sits between the PS/2 byte receiver and the renderer/collision logic. It decodes set-2 make/break sequences, including E0-extended keys, into per-paddle up/down key states. On each `move_tick` it moves every paddle with a speed ramp that accelerates while a key is held, and clamps each paddle to the playfield. It adds a synchronous recenter command and a movement enable.

## Interface
- `NUM_PADDLES`, 2, number of paddles; legal range 1..4.
- `Y_W`, 10, width of each paddle Y coordinate.
- `SCREEN_H`, 480, playfield height in lines.
- `PADDLE_H`, 60, paddle height in lines.
- `SPEED_MIN`, 2, step in lines per tick at the start of a press; must be ≥1.
- `SPEED_MAX`, 8, ceiling for the step; must be ≥ `SPEED_MIN`.
- `ACCEL_TICKS`, 8, held ticks per speed increment; must be ≥2.
- `KEYMAP`, {9'h072,9'h075,9'h172,9'h175,9'h042,9'h043,9'h01B,9'h01D}, packed 9-bit codes at `[18p+8:18p]` = up and `[18p+17:18p+9]` = down for paddle p. bit8 = E0-extended. Default: P0 W/S, P1 I/K, P2 arrow up/down, P3 keypad 8/2.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `move_tick` input 1: one-cycle movement strobe.
- `scan_code` input 8: PS/2 byte.
- `scan_ready` input 1: `scan_code` valid this cycle; one-cycle pulse.
- `center` input 1: synchronous recenter all paddles.
- `enable` input 1: movement enable; key tracking is unaffected.
- `paddle_y` output `NUM_PADDLES*Y_W`: paddle p top Y at `[Y_W*p+:Y_W]`.
- `key_state` output `2*NUM_PADDLES`: bit 2p = up held, bit 2p+1 = down held.

## Operation
- Decoder FSM, advanced only when `scan_ready`=1. States: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0→EXT; F0→BRK; other byte→make of {0,byte}, stay in IDLE.
  - EXT: F0→EXT_BRK; E0→stay in EXT; other byte→make of {1,byte}, go to IDLE.
  - BRK: any byte other than E0/F0→break of {0,byte}, go to IDLE. E0→EXT_BRK. F0→stay in BRK.
  - EXT_BRK: any byte other than E0/F0→break of {1,byte}, go to IDLE. E0/F0→stay in EXT_BRK.
- Make sets and break clears every `key_state` bit whose `KEYMAP` entry equals the 9-bit code. Codes not in the map are ignored, but the FSM still returns to IDLE.
- Per paddle, direction d is derived from `key_state`:
  - UP = up held and down not held.
  - DOWN = down held and up not held.
  - NONE = otherwise, including both held.
- Per-paddle registers: `last_dir`, `speed`, and `hold_cnt` (log2 ACCEL_TICKS bits).
- On a qualifying tick (`move_tick`=1, `enable`=1, `center`=0), for each paddle:
  - d=NONE: no move; `last_dir`=NONE, `speed`=`SPEED_MIN`, `hold_cnt`=0.
  - d≠`last_dir`: step=`SPEED_MIN`; `speed`=`SPEED_MIN`, `hold_cnt`=1, `last_dir`=d.
  - d=`last_dir`: step=`speed`.
    - If `hold_cnt`=`ACCEL_TICKS`-1: `hold_cnt`=0 and `speed`=min(`speed`+1, `SPEED_MAX`).
    - Otherwise `hold_cnt`++.
  - Net effect: ticks 1..A of a hold step by `SPEED_MIN`, ticks A+1..2A by `SPEED_MIN`+1, and so on up to `SPEED_MAX`.
- Clamping uses `Y_W`+1-bit arithmetic, with YMAX = `SCREEN_H`-`PADDLE_H`.
  - UP: y = (y ≥ step) ? y-step : 0.
  - DOWN: y = (y+step ≤ YMAX) ? y+step : YMAX.
  - A paddle resting at a bound still advances its ramp state.
- `center`=1: every y = YMAX/2 (210 with defaults); all ramp state resets (NONE, `SPEED_MIN`, 0). `center` has priority over `move_tick`. Key tracking continues.
- `enable`=0: `move_tick` is ignored and ramp state resets, so re-enabling starts at `SPEED_MIN`.

## Timing
- Reset values:
  - `paddle_y` = YMAX/2 for all paddles.
  - `key_state` = 0.
  - FSM = IDLE.
  - `speed` = `SPEED_MIN`, `hold_cnt` = 0, `last_dir` = NONE.
- `key_state` updates on the clock edge that samples `scan_ready`. It is visible the following cycle.
- Movement uses the registered `key_state`. A byte and `move_tick` in the same cycle: the move uses the pre-update state.
- `paddle_y` updates on the edge sampling `move_tick`, with 1-cycle latency. There are no combinational input→output paths.
- An asynchronous reset mid-sequence (e.g. after E0 F0) discards the partial sequence.

## Test plan
- Reset, then bytes 1D; 8 ticks → P0 y = 210→194 in steps of 2. Tick 9 → 191 (step 3). Bytes F0 1D, then tick → y unchanged; next press moves by 2 again.
- Bytes E0 75 → `key_state`[4]=1 and P3 (keypad 8, code 75) unaffected. Bytes 75 → `key_state`[6]=1. Bytes E0 F0 75 → only bit 4 clears.
- P1 held down (42) from y=210 for many ticks → y saturates at 420 and stays there. Holding I from y=1 (after stepping) → clamps at 0, never wraps.
- W and S both held → P0 y constant over 5 ticks. Release S → P0 moves up by `SPEED_MIN` on the next tick.
- Hold W for 20 ticks, then pulse `center` together with `move_tick` → all y=210. Next tick → step 2.
- `enable`=0 with W held over 10 ticks → y constant and `key_state` still tracks bytes. Assert `rst_n` low between E0 and F0 → FSM returns to IDLE. Then 1D → make of W.
